// File: rtl/inst_pkg.sv
// -----------------------------------------------------------------------------
// inst_pkg
// Shared definitions for the instruction dispatcher: opcode constants,
// instruction field bit positions, the dispatcher FSM state type and a small
// opcode classification helper.
// -----------------------------------------------------------------------------
package inst_pkg;

   // Opcodes (instruction bits [27:25])
   localparam logic [2:0] OP_MEM  = 3'b000;
   localparam logic [2:0] OP_CMP0 = 3'b100;
   localparam logic [2:0] OP_CMP1 = 3'b101;
   localparam logic [2:0] OP_CMP2 = 3'b110;

   // Common field
   localparam int OPC_HI  = 27;
   localparam int OPC_LO  = 25;

   // Memory instruction fields
   localparam int ADDR_HI = 24;
   localparam int ADDR_LO = 13;
   localparam int LEN_HI  = 12;
   localparam int LEN_LO  = 7;
   localparam int PORT_HI = 6;
   localparam int PORT_LO = 5;
   localparam int RSVD_HI = 4;   // bits [4:0] are reserved zero

   // Compute instruction fields
   localparam int CA_HI   = 24;
   localparam int CA_LO   = 21;
   localparam int CB_HI   = 20;
   localparam int CB_LO   = 17;
   localparam int CC_HI   = 16;
   localparam int CC_LO   = 13;
   localparam int MODE_HI = 12;
   localparam int MODE_LO = 11;

   localparam int LEN_W   = LEN_HI - LEN_LO + 1;

   typedef enum logic [1:0] {
      IDLE,
      MEM,
      CMP_ISSUE,
      CMP_WAIT
   } state_t;

   function automatic logic is_cmp_op(input logic [2:0] op);
      return (op == OP_CMP0) || (op == OP_CMP1) || (op == OP_CMP2);
   endfunction

endpackage

// File: rtl/inst_fifo.sv
// -----------------------------------------------------------------------------
// inst_fifo
// Small synchronous FIFO buffering instruction words ahead of the dispatcher.
// Push into a full FIFO and pop from an empty FIFO are ignored. Simultaneous
// push and pop both take effect.
//
// Parameters: WIDTH (word width), DEPTH (entries, power of two, >= 2)
// Ports:
//   clk, rstn        clock / asynchronous active-low reset
//   push, din        write request and data
//   pop              read request (advances head)
//   full, empty      occupancy flags
//   head             oldest entry (valid when !empty)
// -----------------------------------------------------------------------------
module inst_fifo #(
   parameter int WIDTH = 28,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign head  = r_mem[r_rd_ptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers define validity,
   // and leaving the array reset-free lets it map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/inst_dispatch.sv
// -----------------------------------------------------------------------------
// inst_dispatch
// Buffers instruction words and dispatches them one at a time: memory
// instructions become a burst of mem_en cycles with incrementing address,
// compute instructions become a valid/ready issue followed by a wait for the
// completion pulse. Illegal opcodes are dropped with a one-cycle err pulse.
//
// Optional feature: define INST_DISPATCH_PERF_EN to add perf_retired[15:0],
// a saturating count of retired mem/cmp instructions.
//
// Ports:
//   clk, rstn                 clock / asynchronous active-low reset
//   inst, inst_valid          instruction word and its valid
//   inst_ready                high while the buffer has room
//   mem_en/addr/port/last     memory burst beat, address, port, final beat
//   cmp_valid, cmp_ready      compute issue handshake
//   cmp_opcode/a/b/c/mode     compute fields, stable while cmp_valid
//   cmp_done                  compute completion pulse
//   busy                      work pending or in progress
//   err                       one-cycle illegal-opcode pulse
//   perf_retired              (INST_DISPATCH_PERF_EN only) retire counter
// -----------------------------------------------------------------------------
module inst_dispatch
   import inst_pkg::*;
#(
   parameter int INST_WIDTH = 28,
   parameter int ADDR_WIDTH = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [INST_WIDTH-1:0] inst,
   input  logic                  inst_valid,
   output logic                  inst_ready,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [1:0]            mem_port,
   output logic                  mem_last,
   output logic                  cmp_valid,
   input  logic                  cmp_ready,
   output logic [2:0]            cmp_opcode,
   output logic [3:0]            cmp_a,
   output logic [3:0]            cmp_b,
   output logic [3:0]            cmp_c,
   output logic [1:0]            cmp_mode,
   input  logic                  cmp_done,
   output logic                  busy,
   output logic                  err
`ifdef INST_DISPATCH_PERF_EN
   ,
   output logic [15:0]           perf_retired
`endif
);

   state_t                r_state;
   logic                  r_mem_en;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [1:0]            r_mem_port;
   logic                  r_mem_last;
   logic [LEN_W-1:0]      r_remain;
   logic                  r_cmp_valid;
   logic [2:0]            r_cmp_opcode;
   logic [3:0]            r_cmp_a;
   logic [3:0]            r_cmp_b;
   logic [3:0]            r_cmp_c;
   logic [1:0]            r_cmp_mode;
   logic                  r_err;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [INST_WIDTH-1:0] w_head;
   logic [2:0]            w_opcode;
   logic [LEN_W-1:0]      w_len;
   logic                  w_unused;

   assign w_push   = inst_valid && !w_full;
   // Every head seen in IDLE is consumed: dispatched, retired or discarded.
   assign w_pop    = (r_state == IDLE) && !w_empty;
   assign w_opcode = w_head[OPC_HI:OPC_LO];
   assign w_len    = w_head[LEN_HI:LEN_LO];
   assign w_unused = ^w_head[RSVD_HI:0];

   inst_fifo #(
      .WIDTH (INST_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (w_push),
      .din   (inst),
      .pop   (w_pop),
      .full  (w_full),
      .empty (w_empty),
      .head  (w_head)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= IDLE;
         r_mem_en     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_port   <= '0;
         r_mem_last   <= 1'b0;
         r_remain     <= '0;
         r_cmp_valid  <= 1'b0;
         r_cmp_opcode <= '0;
         r_cmp_a      <= '0;
         r_cmp_b      <= '0;
         r_cmp_c      <= '0;
         r_cmp_mode   <= '0;
         r_err        <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  if (w_opcode == OP_MEM) begin
                     // A zero-length burst retires here without leaving IDLE.
                     if (w_len != '0) begin
                        r_state    <= MEM;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= ADDR_WIDTH'(w_head[ADDR_HI:ADDR_LO]);
                        r_mem_port <= w_head[PORT_HI:PORT_LO];
                        r_mem_last <= (w_len == LEN_W'(1));
                        r_remain   <= w_len;
                     end
                  end else if (is_cmp_op(w_opcode)) begin
                     r_state      <= CMP_ISSUE;
                     r_cmp_valid  <= 1'b1;
                     r_cmp_opcode <= w_opcode;
                     r_cmp_a      <= w_head[CA_HI:CA_LO];
                     r_cmp_b      <= w_head[CB_HI:CB_LO];
                     r_cmp_c      <= w_head[CC_HI:CC_LO];
                     r_cmp_mode   <= w_head[MODE_HI:MODE_LO];
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            MEM: begin
               // r_remain counts beats still to present, including this one.
               if (r_remain == LEN_W'(1)) begin
                  r_state    <= IDLE;
                  r_mem_en   <= 1'b0;
                  r_mem_last <= 1'b0;
               end else begin
                  r_mem_addr <= r_mem_addr + 1'b1;
                  r_remain   <= r_remain - 1'b1;
                  r_mem_last <= (r_remain == LEN_W'(2));
               end
            end
            CMP_ISSUE: begin
               if (cmp_ready) begin
                  r_state     <= CMP_WAIT;
                  r_cmp_valid <= 1'b0;
               end
            end
            CMP_WAIT: begin
               if (cmp_done) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef INST_DISPATCH_PERF_EN
   logic        w_retire;
   logic [15:0] r_perf_retired;

   assign w_retire = ((r_state == IDLE) && !w_empty && (w_opcode == OP_MEM) &&
                      (w_len == '0)) ||
                     ((r_state == MEM) && (r_remain == LEN_W'(1))) ||
                     ((r_state == CMP_WAIT) && cmp_done);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_perf_retired <= '0;
      end else if (w_retire && (r_perf_retired != 16'hFFFF)) begin
         r_perf_retired <= r_perf_retired + 16'd1;
      end
   end

   assign perf_retired = r_perf_retired;
`endif

   assign inst_ready = !w_full;
   assign busy       = (r_state != IDLE) || !w_empty;
   assign err        = r_err;
   assign mem_en     = r_mem_en;
   assign mem_addr   = r_mem_addr;
   assign mem_port   = r_mem_port;
   assign mem_last   = r_mem_last;
   assign cmp_valid  = r_cmp_valid;
   assign cmp_opcode = r_cmp_opcode;
   assign cmp_a      = r_cmp_a;
   assign cmp_b      = r_cmp_b;
   assign cmp_c      = r_cmp_c;
   assign cmp_mode   = r_cmp_mode;

endmodule

// File: tb/tb_inst_dispatch.sv
// -----------------------------------------------------------------------------
// tb_inst_dispatch
// Self-checking bench for inst_dispatch: directed scenarios plus a randomized
// stream scored against a transaction-level model of the dispatcher.
// -----------------------------------------------------------------------------
module tb_inst_dispatch;

   logic        clk;
   logic        rstn;
   logic [27:0] inst;
   logic        inst_valid;
   logic        inst_ready;
   logic        mem_en;
   logic [11:0] mem_addr;
   logic [1:0]  mem_port;
   logic        mem_last;
   logic        cmp_valid;
   logic        cmp_ready;
   logic [2:0]  cmp_opcode;
   logic [3:0]  cmp_a;
   logic [3:0]  cmp_b;
   logic [3:0]  cmp_c;
   logic [1:0]  cmp_mode;
   logic        cmp_done;
   logic        busy;
   logic        err;
`ifdef INST_DISPATCH_PERF_EN
   logic [15:0] perf_retired;
`endif

   inst_dispatch #(
      .INST_WIDTH (28),
      .ADDR_WIDTH (12),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .inst       (inst),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .mem_en     (mem_en),
      .mem_addr   (mem_addr),
      .mem_port   (mem_port),
      .mem_last   (mem_last),
      .cmp_valid  (cmp_valid),
      .cmp_ready  (cmp_ready),
      .cmp_opcode (cmp_opcode),
      .cmp_a      (cmp_a),
      .cmp_b      (cmp_b),
      .cmp_c      (cmp_c),
      .cmp_mode   (cmp_mode),
      .cmp_done   (cmp_done),
      .busy       (busy),
      .err        (err)
`ifdef INST_DISPATCH_PERF_EN
      ,
      .perf_retired (perf_retired)
`endif
   );

   typedef struct {
      logic [11:0] addr;
      logic [1:0]  port;
      logic        last;
      int          cyc;
   } beat_t;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   beat_t       obs_mem[$];
   logic [16:0] obs_cmp[$];
   int          err_cnt = 0;
   int          wait_viol = 0;
   int          stab_viol = 0;
   bit          waiting = 0;
   bit          prev_pend = 0;
   logic [16:0] prev_fields = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Passive monitor, sampling on the falling edge.
   always @(negedge clk) begin
      beat_t b;
      if (!rstn) begin
         waiting   = 0;
         prev_pend = 0;
      end else begin
         if (mem_en) begin
            b.addr = mem_addr;
            b.port = mem_port;
            b.last = mem_last;
            b.cyc  = cyc;
            obs_mem.push_back(b);
         end
         if (err) err_cnt++;
         if (waiting && (mem_en || cmp_valid)) wait_viol++;
         if (prev_pend && (!cmp_valid ||
             {cmp_opcode, cmp_a, cmp_b, cmp_c, cmp_mode} !== prev_fields))
            stab_viol++;
         if (waiting && cmp_done) waiting = 0;
         if (cmp_valid && cmp_ready) begin
            obs_cmp.push_back({cmp_opcode, cmp_a, cmp_b, cmp_c, cmp_mode});
            waiting = 1;
         end
         prev_pend   = cmp_valid && !cmp_ready;
         prev_fields = {cmp_opcode, cmp_a, cmp_b, cmp_c, cmp_mode};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [27:0] mk_mem(input int addr, input int len, input int port);
      logic [27:0] w;
      w = '0;
      w[24:13] = 12'(addr);
      w[12:7]  = 6'(len);
      w[6:5]   = 2'(port);
      return w;
   endfunction

   function automatic logic [27:0] mk_cmp(input logic [2:0] op, input int a, input int b,
                                          input int c, input int mode);
      logic [27:0] w;
      w = '0;
      w[27:25] = op;
      w[24:21] = 4'(a);
      w[20:17] = 4'(b);
      w[16:13] = 4'(c);
      w[12:11] = 2'(mode);
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [27:0] w, output int n);
      int k;
      inst       = w;
      inst_valid = 1'b1;
      k = 0;
      while (!inst_ready && k < 50) begin
         step();
         k++;
      end
      if (!inst_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL push_timeout: inst_ready=%0b required 1", inst_ready);
      end
      n = cyc;
      step();
      inst_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while (busy && k < bound) begin
         step();
         k++;
      end
      if (busy) begin
         n_cmp++; n_fail++;
         $display("FAIL idle_timeout: busy=%0b required 0", busy);
      end
   endtask

   // Handshakes every compute issue and completes it the following cycle.
   task automatic serve_cmps(input int target);
      int k;
      bit hs;
      k  = 0;
      hs = 0;
      while (obs_cmp.size() < target && k < 500) begin
         cmp_done  = hs;
         hs        = 0;
         cmp_ready = cmp_valid;
         if (cmp_valid) hs = 1;
         step();
         k++;
      end
      cmp_ready = 1'b0;
      cmp_done  = hs;
      step();
      cmp_done  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      n_cmp++;
      if ({inst_ready, mem_en, mem_addr, mem_port, mem_last, busy, err} !==
          {1'b1, 1'b0, 12'd0, 2'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL %s_mem: ready=%0b en=%0b addr=%0d port=%0d last=%0b busy=%0b err=%0b required 1/0/0/0/0/0/0",
                  tag, inst_ready, mem_en, mem_addr, mem_port, mem_last, busy, err);
      end
      n_cmp++;
      if ({cmp_valid, cmp_opcode, cmp_a, cmp_b, cmp_c, cmp_mode} !== 18'd0) begin
         n_fail++;
         $display("FAIL %s_cmp: valid=%0b fields=%0h required 0",
                  tag, cmp_valid, {cmp_opcode, cmp_a, cmp_b, cmp_c, cmp_mode});
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; inst = '0; inst_valid = 1'b0; cmp_ready = 1'b0; cmp_done = 1'b0;
      step(); step(); step();
      check_reset_outputs("reset_held");
      rstn = 1'b1;
      step(); step();
      check_reset_outputs("reset_released");
   endtask

   task automatic check_burst(input string tag, input int addr, input int len,
                              input int port, input int first_cyc);
      int ea;
      n_cmp++;
      if (obs_mem.size() != len) begin
         n_fail++;
         $display("FAIL %s_beats: got %0d required %0d", tag, obs_mem.size(), len);
      end else begin
         for (int i = 0; i < len; i++) begin
            ea = (addr + i) % 4096;
            n_cmp++;
            if (obs_mem[i].addr !== 12'(ea) || obs_mem[i].port !== 2'(port) ||
                obs_mem[i].last !== (i == len - 1) || obs_mem[i].cyc != first_cyc + i) begin
               n_fail++;
               $display("FAIL %s_beat%0d: addr=%0d port=%0d last=%0b cyc=%0d required %0d/%0d/%0b/%0d",
                        tag, i, obs_mem[i].addr, obs_mem[i].port, obs_mem[i].last,
                        obs_mem[i].cyc, ea, port, (i == len - 1), first_cyc + i);
            end
         end
      end
   endtask

   task automatic test_mem_basic();
      int n;
      obs_mem.delete();
      push(mk_mem(100, 4, 0), n);
      wait_idle(50);
      check_burst("mem_basic", 100, 4, 0, n + 2);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mem_basic_busy: got %0b required 0", busy);
      end
   endtask

   task automatic test_mem_wrap();
      int n;
      obs_mem.delete();
      push(mk_mem(4094, 3, 2), n);
      wait_idle(50);
      check_burst("mem_wrap", 4094, 3, 2, n + 2);
   endtask

   task automatic test_cmp_hold();
      int n, n2, d, bad;
      obs_mem.delete();
      obs_cmp.delete();
      wait_viol = 0;
      stab_viol = 0;
      push(mk_cmp(3'b100, 1, 2, 3, 0), n);
      push(mk_mem(500, 2, 1), n2);
      // Now in cycle n+2: the compute issue must be visible.
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({cmp_valid, cmp_opcode, cmp_a, cmp_b, cmp_c, cmp_mode} !==
             {1'b1, 3'b100, 4'd1, 4'd2, 4'd3, 2'd0}) begin
            n_fail++;
            $display("FAIL cmp_hold_c%0d: valid=%0b fields=%0h required 1/%0h",
                     i, cmp_valid, {cmp_opcode, cmp_a, cmp_b, cmp_c, cmp_mode},
                     {3'b100, 4'd1, 4'd2, 4'd3, 2'd0});
         end
         step();
      end
      cmp_ready = 1'b1;
      step();
      cmp_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (mem_en || cmp_valid) bad++;
         step();
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL cmp_wait_block: %0d issuing cycles while waiting, required 0", bad);
      end
      cmp_done = 1'b1;
      d = cyc;
      step();
      cmp_done = 1'b0;
      wait_idle(50);
      check_burst("cmp_next", 500, 2, 1, d + 2);
      n_cmp++;
      if (obs_cmp.size() != 1 || wait_viol != 0 || stab_viol != 0) begin
         n_fail++;
         $display("FAIL cmp_hold_proto: issues=%0d wait_viol=%0d stab_viol=%0d required 1/0/0",
                  obs_cmp.size(), wait_viol, stab_viol);
      end
   endtask

   task automatic test_fifo_full();
      logic [27:0] w[5];
      logic [16:0] exp_q[$];
      int n, k, d;
      obs_cmp.delete();
      exp_q.delete();
      push(mk_cmp(3'b101, 15, 0, 7, 3), n);
      exp_q.push_back(mk_cmp(3'b101, 15, 0, 7, 3) >> 11);
      k = 0;
      while (!cmp_valid && k < 20) begin step(); k++; end
      cmp_ready = 1'b1;
      step();
      cmp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w[i] = mk_cmp(3'(4 + (i % 3)), i + 1, 2 * i, 15 - i, i % 4);
         exp_q.push_back(w[i] >> 11);
      end
      for (int i = 0; i < 4; i++) begin
         inst = w[i];
         inst_valid = 1'b1;
         n_cmp++;
         if (inst_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_accept%0d: inst_ready=%0b required 1", i, inst_ready);
         end
         step();
      end
      inst = w[4];
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (inst_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_block%0d: inst_ready=%0b required 0", i, inst_ready);
         end
         step();
      end
      cmp_done = 1'b1;
      d = cyc;
      step();
      cmp_done = 1'b0;
      k = 0;
      while (!inst_ready && k < 10) begin step(); k++; end
      n_cmp++;
      if (cyc != d + 2) begin
         n_fail++;
         $display("FAIL full_reaccept: accepted in cycle %0d required %0d", cyc, d + 2);
      end
      step();
      inst_valid = 1'b0;
      serve_cmps(6);
      wait_idle(50);
      n_cmp++;
      if (obs_cmp.size() != exp_q.size() || obs_cmp != exp_q) begin
         n_fail++;
         $display("FAIL full_order: got %0d issues, first=%0h required %0d issues, first=%0h",
                  obs_cmp.size(), (obs_cmp.size() > 1) ? obs_cmp[1] : 17'd0,
                  exp_q.size(), exp_q[1]);
      end
   endtask

   task automatic test_illegal();
      int n;
      obs_mem.delete();
      err_cnt = 0;
      push({3'b111, 25'h0ABCDEF}, n);
      push(mk_mem(77, 0, 3), n);
      for (int i = 0; i < 10; i++) step();
      n_cmp++;
      if (err_cnt != 1) begin
         n_fail++;
         $display("FAIL illegal_err: %0d err cycles required 1", err_cnt);
      end
      n_cmp++;
      if (obs_mem.size() != 0 || busy !== 1'b0 || inst_ready !== 1'b1 || cmp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_drain: beats=%0d busy=%0b ready=%0b cmp_valid=%0b required 0/0/1/0",
                  obs_mem.size(), busy, inst_ready, cmp_valid);
      end
   endtask

   task automatic test_reset_mid();
      int n, n2, seen;
      obs_mem.delete();
      push(mk_mem(200, 8, 1), n);
      push(mk_mem(300, 2, 0), n2);
      step();
      n_cmp++;
      if (mem_en !== 1'b1 || mem_addr !== 12'd201) begin
         n_fail++;
         $display("FAIL rstmid_beat2: en=%0b addr=%0d required 1/201", mem_en, mem_addr);
      end
      #1 rstn = 1'b0;
      #1;
      check_reset_outputs("rstmid_async");
      seen = obs_mem.size();
      step(); step();
      rstn = 1'b1;
      for (int i = 0; i < 20; i++) step();
      n_cmp++;
      if (obs_mem.size() != seen || busy !== 1'b0 || inst_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_quiet: beats=%0d busy=%0b ready=%0b required %0d/0/1",
                  obs_mem.size(), busy, inst_ready, seen);
      end
   endtask

   task automatic test_random();
      beat_t       exp_mem[$];
      logic [16:0] exp_cmp[$];
      beat_t       b;
      logic [27:0] w;
      logic [2:0]  bad_ops[4];
      int          exp_err, r, len, k, mem_bad;
      bit          have_word;
      bad_ops[0] = 3'b001; bad_ops[1] = 3'b010; bad_ops[2] = 3'b011; bad_ops[3] = 3'b111;
      obs_mem.delete();
      obs_cmp.delete();
      err_cnt = 0; wait_viol = 0; stab_viol = 0; exp_err = 0;
      have_word = 0;
      w = '0;
      for (int c = 0; c < 3000; c++) begin
         if (!have_word) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)
               w = mk_mem(int'($urandom_range(0, 4095)), int'($urandom_range(0, 6)),
                          int'($urandom_range(0, 3)));
            else if (r < 9)
               w = mk_cmp(3'(4 + $urandom_range(0, 2)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)));
            else
               w = {bad_ops[$urandom_range(0, 3)], 25'($urandom)};
            have_word = 1;
         end
         inst       = w;
         inst_valid = ($urandom_range(0, 2) != 0);
         cmp_ready  = 1'($urandom_range(0, 1));
         cmp_done   = ($urandom_range(0, 3) == 0);
         if (inst_valid && inst_ready) begin
            have_word = 0;
            if (w[27:25] == 3'b000) begin
               len = int'(w[12:7]);
               for (int i = 0; i < len; i++) begin
                  b.addr = 12'((int'(w[24:13]) + i) % 4096);
                  b.port = w[6:5];
                  b.last = (i == len - 1);
                  b.cyc  = 0;
                  exp_mem.push_back(b);
               end
            end else if (w[27:25] inside {3'b100, 3'b101, 3'b110}) begin
               exp_cmp.push_back(w[27:11]);
            end else begin
               exp_err++;
            end
         end
         step();
      end
      inst_valid = 1'b0;
      k = 0;
      while (busy && k < 2000) begin
         cmp_ready = 1'($urandom_range(0, 1));
         cmp_done  = ($urandom_range(0, 3) == 0);
         step();
         k++;
      end
      cmp_ready = 1'b0;
      cmp_done  = 1'b0;
      step();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rand_drain: busy=%0b required 0", busy);
      end
      mem_bad = 0;
      if (obs_mem.size() != exp_mem.size()) mem_bad = 1;
      else
         for (int i = 0; i < exp_mem.size(); i++)
            if (obs_mem[i].addr !== exp_mem[i].addr || obs_mem[i].port !== exp_mem[i].port ||
                obs_mem[i].last !== exp_mem[i].last) mem_bad++;
      n_cmp++;
      if (mem_bad != 0) begin
         n_fail++;
         $display("FAIL rand_mem: %0d beats observed, %0d required, %0d differing",
                  obs_mem.size(), exp_mem.size(), mem_bad);
      end
      n_cmp++;
      if (obs_cmp.size() != exp_cmp.size() || obs_cmp != exp_cmp) begin
         n_fail++;
         $display("FAIL rand_cmp: %0d issues observed, %0d required (or order differs)",
                  obs_cmp.size(), exp_cmp.size());
      end
      n_cmp++;
      if (err_cnt != exp_err) begin
         n_fail++;
         $display("FAIL rand_err: got %0d err pulses required %0d", err_cnt, exp_err);
      end
      n_cmp++;
      if (wait_viol != 0 || stab_viol != 0) begin
         n_fail++;
         $display("FAIL rand_proto: wait_viol=%0d stab_viol=%0d required 0/0",
                  wait_viol, stab_viol);
      end
   endtask

   initial begin
      test_reset();
      test_mem_basic();
      test_mem_wrap();
      test_cmp_hold();
      test_fifo_full();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_dispatch.md
INST_DISPATCH -- requirements
Module: inst_dispatch

Interface
REQ-001 The block SHALL have parameter INST_WIDTH, default 28, meaning instruction word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, meaning memory address width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two), meaning instruction buffer entries.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock, all state on rising edge.
REQ-005 The block SHALL have the reset port rstn  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have inst  in  INST_WIDTH  instruction word; mem fields {opcode[27:25], addr[24:13], length[12:7], port[6:5], 0[4:0]}; cmp fields {opcode[27:25], A[24:21], B[20:17], C[16:13], mode[12:11], 0}.
REQ-007 The block SHALL have inst_valid  in  1, and inst_ready  out  1 (high when FIFO not full).
REQ-008 The block SHALL have mem_en  out  1, mem_addr  out  ADDR_WIDTH, mem_port  out  2, and mem_last  out  1 (final word of a burst).
REQ-009 The block SHALL have cmp_valid  out  1 and cmp_ready  in  1, together with cmp_opcode  out  3, cmp_a/cmp_b/cmp_c  out  4 each, and cmp_mode  out  2.
REQ-010 The block SHALL have cmp_done  in  1 (single-cycle completion pulse), busy  out  1, and err  out  1 (one-cycle illegal-opcode pulse).

Function
REQ-011 A push SHALL occur when inst_valid && inst_ready, and a pop when the FSM leaves IDLE with a head entry; push and pop in the same cycle SHALL both take effect.
REQ-012 The FSM SHALL have exactly the states IDLE, MEM, CMP_ISSUE, CMP_WAIT.
REQ-013 In IDLE with the FIFO non-empty, the head SHALL be popped and decoded: opcode 000 -> MEM; opcode 100/101/110 -> CMP_ISSUE; any other opcode -> stay IDLE, err=1 for that cycle, entry discarded.
REQ-014 MEM SHALL assert mem_en for exactly length consecutive cycles with mem_addr = addr, addr+1, ..., modulo 2^ADDR_WIDTH, mem_port constant, and mem_last high on the final cycle, then return to IDLE.
REQ-015 An instruction with length=0 SHALL produce no mem_en cycle, shall retire in the decode cycle, and the FSM shall remain IDLE.
REQ-016 Latency SHALL be: a word pushed into an empty FIFO while IDLE at cycle N gives first mem_en or cmp_valid at cycle N+2.
REQ-017 CMP_ISSUE SHALL hold cmp_valid with fields stable until cmp_ready; then -> CMP_WAIT.
REQ-018 CMP_WAIT SHALL stay until cmp_done, then -> IDLE; a cmp_done in any other state SHALL be ignored.
REQ-019 A new head SHALL be decoded in the cycle after returning to IDLE (one bubble between instructions).
REQ-020 busy SHALL be high when state != IDLE or the FIFO is non-empty.
REQ-021 A full FIFO SHALL hold inst_ready low, and inst_valid while full SHALL be ignored and not overwrite.

Reset
REQ-022 rstn low SHALL asynchronously force: state IDLE, FIFO empty, inst_ready=1, mem_en=0, mem_addr=0, mem_port=0, mem_last=0, cmp_valid=0, cmp fields 0, busy=0, err=0.
REQ-023 Reset mid-burst or mid-handshake SHALL abort with no further mem_en/cmp_valid; buffered instructions SHALL be lost.

Configuration
REQ-024 With INST_DISPATCH_PERF_EN defined, the block SHALL add output perf_retired[15:0], which counts retired mem/cmp instructions, saturates at 16'hFFFF, and resets to 0.
REQ-025 Without INST_DISPATCH_PERF_EN, the port and its counter SHALL be absent, with behaviour otherwise identical.

Structure
REQ-026 Shared package inst_pkg SHALL hold the opcode constants (OP_MEM=3'b000, OP_CMP0=3'b100, OP_CMP1=3'b101, OP_CMP2=3'b110), the field bit-position constants, and the FSM state typedef.
REQ-027 The FIFO SHALL be the sub-module inst_fifo (parameters width and depth; push/pop/full/empty/head).

Verification
REQ-028 Test: mem instruction addr=100, length=4, port=0 -> mem_en cycles with addresses 100,101,102,103; mem_last on 103; busy low afterwards.
REQ-029 Test: addr=4094, length=3, port=2 -> addresses 4094, 4095, 0; mem_port=2 throughout.
REQ-030 Test: cmp opcode 100, A=1, B=2, C=3, mode=0 with cmp_ready delayed 3 cycles -> cmp_valid held with stable fields; the next instruction is not issued until cmp_done.
REQ-031 Test: 5 back-to-back pushes while a cmp waits -> inst_ready low after the 4th buffered entry; the 5th accepted only after a pop; order preserved.
REQ-032 Test: opcode 111, then length=0 mem instruction -> one err pulse, no mem_en, FIFO drains, FSM stays IDLE.
REQ-033 Test: rstn low during the 2nd word of a length=8 burst -> all outputs at reset values immediately, with no mem_en after release until a new push.
